wb_apb_arbiter: RTL

WB_APB_ARBITER -- requirements
Module: wb_apb_arbiter

---
 rtl/wb_apb_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/wb_apb_arbiter.sv
// Wishbone N-to-1 round-robin arbiter in front of a WB-to-APB bridge.
// One master owns the shared slave port from grant until it drops cyc.
// A stalled strobe is abandoned after TIMEOUT cycles with a one-cycle
// error pulse. The slave port then stays quiet until the owner releases cyc.
module wb_apb_arbiter #(
    parameter int          NUM_MASTERS   = 4,
    parameter int          WB_ADDR_WIDTH = 32,
    parameter int          WB_DATA_WIDTH = 32,
    parameter int          WB_SEL_WIDTH  = 4,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_MASTERS-1:0]                 m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                 m_stb_i,
    input  logic [NUM_MASTERS-1:0]                 m_we_i,
    input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]    m_sel_i,
    output logic [NUM_MASTERS-1:0]                 m_ack_o,
    output logic [NUM_MASTERS-1:0]                 m_err_o,
    output logic [NUM_MASTERS-1:0]                 m_gnt_o,
    output logic [WB_DATA_WIDTH-1:0]               m_dat_o,
    output logic                                   s_cyc_o,
    output logic                                   s_stb_o,
    output logic                                   s_we_o,
    output logic [WB_ADDR_WIDTH-1:0]               s_adr_o,
    output logic [WB_DATA_WIDTH-1:0]               s_dat_o,
    output logic [WB_SEL_WIDTH-1:0]                s_sel_o,
    input  logic                                   s_ack_i,
    input  logic                                   s_err_i,
    input  logic [WB_DATA_WIDTH-1:0]               s_dat_i
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t                   state_reg;
    logic [NUM_MASTERS-1:0]   gnt_reg;
    logic [IDX_W-1:0]         gnt_idx_reg;
    logic [IDX_W-1:0]         last_grant_reg;
    logic [15:0]              cnt_reg;
    logic                     err_pulse_reg;

    // Per-master fields unpacked so the owner can be selected by index
    logic [WB_ADDR_WIDTH-1:0] adr_arr [NUM_MASTERS];
    logic [WB_DATA_WIDTH-1:0] dat_arr [NUM_MASTERS];
    logic [WB_SEL_WIDTH-1:0]  sel_arr [NUM_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
            assign adr_arr[gi] = m_adr_i[gi*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
            assign dat_arr[gi] = m_dat_i[gi*WB_DATA_WIDTH +: WB_DATA_WIDTH];
            assign sel_arr[gi] = m_sel_i[gi*WB_SEL_WIDTH +: WB_SEL_WIDTH];
        end
    endgenerate

    // Signals of the currently granted master
    logic cyc_g, stb_g, we_g;
    assign cyc_g = m_cyc_i[gnt_idx_reg];
    assign stb_g = m_stb_i[gnt_idx_reg];
    assign we_g  = m_we_i[gnt_idx_reg];

    logic busy;
    logic stalled;
    logic timeout_hit;
    assign busy        = (state_reg == BUSY);
    assign stalled     = busy && stb_g && !s_ack_i && !s_err_i;
    // The stall that would bring the count up to TIMEOUT ends the transfer
    assign timeout_hit = stalled && (({1'b0, cnt_reg} + 17'd1) == 17'(TIMEOUT));

    // Round-robin search starting just after the previous winner
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] winner_idx;
    logic             winner_found;

    // Pick the first requesting master after last_grant, wrapping around
    always_comb begin
        cand         = '0;
        winner_idx   = '0;
        winner_found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = {1'b0, last_grant_reg} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
                cand = cand - (IDX_W+1)'(NUM_MASTERS);
            end
            if (!winner_found && m_cyc_i[cand[IDX_W-1:0]]) begin
                winner_found = 1'b1;
                winner_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Slave port mirrors the owner only while a transfer may be in flight
    assign s_cyc_o = busy & cyc_g;
    assign s_stb_o = busy & stb_g;
    assign s_we_o  = busy & we_g;
    assign s_adr_o = busy ? adr_arr[gnt_idx_reg] : '0;
    assign s_dat_o = busy ? dat_arr[gnt_idx_reg] : '0;
    assign s_sel_o = busy ? sel_arr[gnt_idx_reg] : '0;

    // Slave responses reach only the owner, and only during BUSY
    assign m_ack_o = (busy && s_ack_i) ? gnt_reg : '0;
    assign m_err_o = ((busy && s_err_i) || err_pulse_reg) ? gnt_reg : '0;
    assign m_dat_o = s_dat_i;
    assign m_gnt_o = gnt_reg;

    // Arbitration FSM with grant, priority pointer and stall counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            gnt_reg        <= '0;
            gnt_idx_reg    <= '0;
            last_grant_reg <= IDX_W'(NUM_MASTERS - 1);
            cnt_reg        <= '0;
            err_pulse_reg  <= 1'b0;
        end else begin
            err_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (winner_found) begin
                        gnt_reg        <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner_idx;
                        gnt_idx_reg    <= winner_idx;
                        last_grant_reg <= winner_idx;
                        state_reg      <= BUSY;
                    end
                end
                BUSY: begin
                    if (!cyc_g) begin
                        gnt_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (timeout_hit) begin
                        err_pulse_reg <= 1'b1;
                        cnt_reg       <= '0;
                        state_reg     <= ABORT;
                    end else if (stalled) begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end else begin
                        cnt_reg <= '0;
                    end
                end
                ABORT: begin
                    cnt_reg <= '0;
                    if (!cyc_g) begin
                        gnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    gnt_reg   <= '0;
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
